// File: rtl/urv_dmem_wb_bridge.sv
// urv_dmem_wb_bridge
//   Responder for the uRV execute-stage data-memory port. It accepts one load
//   or store at a time and runs it as a single Wishbone classic master cycle.
//   Load data and one-cycle load/store completion pulses go back to writeback.
//   Every bus cycle is bounded by a timeout.
//
// Handshake: a request is taken on a clock edge where (dm_load_i | dm_store_i)
//   and dm_ready_o are both high. dm_ready_o is registered and is high exactly
//   while the bridge is idle. Execute holds its strobe through the stall, so
//   strobes seen while dm_ready_o is low are ignored. Completion is signalled
//   by exactly one dm_load_done_o or dm_store_done_o pulse. dm_bus_error_o
//   pulses in the same cycle when the transfer ended on err or on timeout.
//
// Ports
//   clk_i, rst_n_i     clock, synchronous active-low reset
//   dm_*_i             request from execute (address, store data, lane select,
//                      load and store strobes)
//   dm_ready_o         bridge idle, request can be accepted
//   dm_data_l_o        load data, valid with dm_load_done_o, held between loads
//   dm_*_done_o        one-cycle completion pulses
//   dm_bus_error_o     one-cycle error pulse (err or timeout)
//   wb_*               Wishbone classic master port (stb mirrors cyc)
//
// Parameter
//   TIMEOUT_CYCLES     number of stb cycles without ack/err before the cycle is
//                      forced to end with an error; 0 disables the timeout
module urv_dmem_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_bus_error_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUS  = 1'b1;

  // A zero timeout still needs a 1-bit counter to keep the declaration legal.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [0:0]    state;
  logic [CW-1:0] to_cnt;
  logic          req;
  logic          timeout_hit;
  logic          term;

  assign req         = dm_load_i | dm_store_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
  assign term        = wb_err_i | wb_ack_i | timeout_hit;
  assign wb_stb_o    = wb_cyc_o;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state           <= S_IDLE;
      to_cnt          <= '0;
      dm_ready_o      <= 1'b0;
      dm_data_l_o     <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_bus_error_o  <= 1'b0;
      wb_adr_o        <= '0;
      wb_dat_o        <= '0;
      wb_sel_o        <= '0;
      wb_we_o         <= 1'b0;
      wb_cyc_o        <= 1'b0;
    end else begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_bus_error_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req && dm_ready_o) begin
            // A store wins over a simultaneous load; the load is dropped.
            state      <= S_BUS;
            dm_ready_o <= 1'b0;
            wb_adr_o   <= {dm_addr_i[31:2], 2'b00};
            wb_dat_o   <= dm_data_s_i;
            wb_we_o    <= dm_store_i;
            wb_sel_o   <= dm_store_i ? dm_data_select_i : 4'b1111;
            wb_cyc_o   <= 1'b1;
            to_cnt     <= '0;
          end else begin
            dm_ready_o <= 1'b1;
          end
        end
        S_BUS: begin
          if (term) begin
            state      <= S_IDLE;
            dm_ready_o <= 1'b1;
            wb_cyc_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            if (wb_we_o) dm_store_done_o <= 1'b1;
            else         dm_load_done_o  <= 1'b1;
            // err beats ack; without ack the only other cause is the timeout.
            if (wb_err_i || !wb_ack_i) begin
              dm_bus_error_o <= 1'b1;
              if (!wb_we_o) dm_data_l_o <= '0;
            end else if (!wb_we_o) begin
              dm_data_l_o <= wb_dat_i;
            end
          end else if (to_cnt != {CW{1'b1}}) begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_urv_dmem_wb_bridge.sv
module tb_urv_dmem_wb_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dm_addr, dm_data_s, dm_data_l, wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  dm_sel, wb_sel;
  logic        dm_load, dm_store, dm_ready, ld_done, st_done, bus_err;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  urv_dmem_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_load_i(dm_load), .dm_store_i(dm_store), .dm_ready_o(dm_ready),
    .dm_data_l_o(dm_data_l), .dm_load_done_o(ld_done), .dm_store_done_o(st_done),
    .dm_bus_error_o(bus_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  // Advance to just after the next rising edge: outputs are settled there and
  // inputs driven there are sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dm_addr = '0; dm_data_s = '0; dm_sel = '0;
    dm_load = 1'b0; dm_store = 1'b0; wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we, dm_ready, ld_done, st_done, bus_err} !== 7'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b exp 0000000",
        {wb_cyc, wb_stb, wb_we, dm_ready, ld_done, st_done, bus_err});
    end
    n_cmp++;
    if ({wb_adr, wb_dat_o, wb_sel, dm_data_l} !== 100'h0) begin
      n_bad++; $display("FAIL reset_data got adr %h dat %h sel %h dl %h exp all 0",
        wb_adr, wb_dat_o, wb_sel, dm_data_l);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (dm_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready got %b exp 1", dm_ready);
    end
  endtask

  task automatic test_load_fast_ack();
    dm_load = 1'b1; dm_addr = 32'h0000_1006;
    tick();
    dm_load = 1'b0; dm_addr = 32'hFFFF_FFFF;
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, dm_ready} !== {3'b110, 4'hF, 32'h0000_1004, 1'b0}) begin
      n_bad++; $display("FAIL load_bus got cyc%b stb%b we%b sel%h adr%h rdy%b exp cyc1 stb1 we0 selF adr00001004 rdy0",
        wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, dm_ready);
    end
    wb_ack = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h1111_1111;
    n_cmp++;
    if ({ld_done, st_done, bus_err, dm_data_l, wb_cyc, dm_ready} !== {3'b100, 32'hDEAD_BEEF, 2'b01}) begin
      n_bad++; $display("FAIL load_done got ld%b st%b be%b dl%h cyc%b rdy%b exp ld1 st0 be0 dlDEADBEEF cyc0 rdy1",
        ld_done, st_done, bus_err, dm_data_l, wb_cyc, dm_ready);
    end
    tick();
    n_cmp++;
    if ({ld_done, dm_data_l} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL load_pulse_width got ld%b dl%h exp ld0 dlDEADBEEF", ld_done, dm_data_l);
    end
  endtask

  // Ack arrives in the 4th stb cycle, the same edge the timeout counter
  // reaches its last value: ack must win and no error is flagged.
  task automatic test_store_wait();
    int low_cnt;
    dm_store = 1'b1; dm_addr = 32'h0000_2002; dm_data_s = 32'h55AA_55AA; dm_sel = 4'b1100;
    tick();
    dm_store = 1'b0; dm_data_s = '0; dm_sel = '0;
    low_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      if (!dm_ready) low_cnt++;
      n_cmp++;
      if ({wb_cyc, wb_we, wb_sel, wb_dat_o, wb_adr, st_done} !== {2'b11, 4'hC, 32'h55AA_55AA, 32'h0000_2000, 1'b0}) begin
        n_bad++; $display("FAIL store_bus[%0d] got cyc%b we%b sel%h dat%h adr%h st%b exp cyc1 we1 selC dat55AA55AA adr00002000 st0",
          i, wb_cyc, wb_we, wb_sel, wb_dat_o, wb_adr, st_done);
      end
      if (i == 4) wb_ack = 1'b1;
      tick();
    end
    wb_ack = 1'b0;
    n_cmp++;
    if ({st_done, ld_done, bus_err, wb_cyc, wb_we, dm_ready, dm_data_l} !== {6'b100001, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL store_done got st%b ld%b be%b cyc%b we%b rdy%b dl%h exp st1 ld0 be0 cyc0 we0 rdy1 dlDEADBEEF",
        st_done, ld_done, bus_err, wb_cyc, wb_we, dm_ready, dl_str(dm_data_l));
    end
    n_cmp++;
    if (low_cnt != 4) begin
      n_bad++; $display("FAIL store_ready_low got %0d cycles exp 4", low_cnt);
    end
    tick();
  endtask

  function automatic logic [31:0] dl_str(input logic [31:0] v);
    return v;
  endfunction

  task automatic test_timeout();
    int cyc_cnt;
    dm_load = 1'b1; dm_addr = 32'h0000_4000;
    tick();
    dm_load = 1'b0;
    cyc_cnt = 0;
    while (wb_cyc && cyc_cnt < 20) begin
      cyc_cnt++;
      tick();
    end
    n_cmp++;
    if (cyc_cnt != 4) begin
      n_bad++; $display("FAIL timeout_cyc_len got %0d exp 4", cyc_cnt);
    end
    n_cmp++;
    if ({ld_done, st_done, bus_err, dm_ready, wb_cyc, dm_data_l} !== {5'b10110, 32'h0}) begin
      n_bad++; $display("FAIL timeout_done got ld%b st%b be%b rdy%b cyc%b dl%h exp ld1 st0 be1 rdy1 cyc0 dl00000000",
        ld_done, st_done, bus_err, dm_ready, wb_cyc, dm_data_l);
    end
    tick();
  endtask

  // Execute raises store and load together; the store wins, and the load
  // strobe is held through the stall until the bridge is ready again.
  task automatic test_back_to_back();
    dm_store = 1'b1; dm_load = 1'b1; dm_addr = 32'h0000_5008;
    dm_data_s = 32'hA5A5_A5A5; dm_sel = 4'b0011;
    tick();
    dm_store = 1'b0; dm_addr = 32'h0000_600C;
    n_cmp++;
    if ({wb_cyc, wb_we, wb_sel, wb_adr, dm_ready} !== {2'b11, 4'h3, 32'h0000_5008, 1'b0}) begin
      n_bad++; $display("FAIL b2b_store_wins got cyc%b we%b sel%h adr%h rdy%b exp cyc1 we1 sel3 adr00005008 rdy0",
        wb_cyc, wb_we, wb_sel, wb_adr, dm_ready);
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    n_cmp++;
    if ({st_done, ld_done, dm_ready, wb_cyc} !== 4'b1010) begin
      n_bad++; $display("FAIL b2b_store_done got st%b ld%b rdy%b cyc%b exp st1 ld0 rdy1 cyc0",
        st_done, ld_done, dm_ready, wb_cyc);
    end
    tick();
    dm_load = 1'b0;
    n_cmp++;
    if ({wb_cyc, wb_we, wb_sel, wb_adr, st_done, dm_ready} !== {2'b10, 4'hF, 32'h0000_600C, 2'b00}) begin
      n_bad++; $display("FAIL b2b_load_accept got cyc%b we%b sel%h adr%h st%b rdy%b exp cyc1 we0 selF adr0000600C st0 rdy0",
        wb_cyc, wb_we, wb_sel, wb_adr, st_done, dm_ready);
    end
    wb_ack = 1'b1; wb_dat_i = 32'h0BAD_F00D;
    tick();
    wb_dat_i = 32'h7777_7777;
    n_cmp++;
    if ({ld_done, bus_err, dm_data_l} !== {2'b10, 32'h0BAD_F00D}) begin
      n_bad++; $display("FAIL b2b_load_done got ld%b be%b dl%h exp ld1 be0 dl0BADF00D", ld_done, bus_err, dm_data_l);
    end
    // wb_ack is still high here with the bridge idle: a stray ack.
    tick(); tick();
    wb_ack = 1'b0;
    n_cmp++;
    if ({ld_done, st_done, bus_err, wb_cyc, dm_ready, dm_data_l} !== {5'b00001, 32'h0BAD_F00D}) begin
      n_bad++; $display("FAIL stray_ack got ld%b st%b be%b cyc%b rdy%b dl%h exp ld0 st0 be0 cyc0 rdy1 dl0BADF00D",
        ld_done, st_done, bus_err, wb_cyc, dm_ready, dm_data_l);
    end
  endtask

  task automatic test_err_ack();
    dm_load = 1'b1; dm_addr = 32'h0000_3000;
    tick();
    dm_load = 1'b0;
    wb_err = 1'b1; wb_ack = 1'b1; wb_dat_i = 32'h1234_5678;
    tick();
    wb_err = 1'b0; wb_ack = 1'b0;
    n_cmp++;
    if ({ld_done, st_done, bus_err, dm_ready, dm_data_l} !== {4'b1011, 32'h0}) begin
      n_bad++; $display("FAIL err_ack got ld%b st%b be%b rdy%b dl%h exp ld1 st0 be1 rdy1 dl00000000",
        ld_done, st_done, bus_err, dm_ready, dm_data_l);
    end
    tick();
    n_cmp++;
    if (bus_err !== 1'b0) begin
      n_bad++; $display("FAIL err_pulse_width got %b exp 0", bus_err);
    end
  endtask

  task automatic test_reset_mid_cycle();
    bit seen_done;
    dm_load = 1'b1; dm_addr = 32'h0000_7004;
    tick();
    dm_load = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen_done = ld_done | st_done;
    n_cmp++;
    if ({wb_cyc, wb_stb, dm_ready, bus_err} !== 4'b0) begin
      n_bad++; $display("FAIL midrst_abort got cyc%b stb%b rdy%b be%b exp all 0", wb_cyc, wb_stb, dm_ready, bus_err);
    end
    tick();
    seen_done = seen_done | ld_done | st_done;
    n_cmp++;
    if ({dm_ready, seen_done} !== 2'b10) begin
      n_bad++; $display("FAIL midrst_recover got rdy%b done_seen%b exp rdy1 done_seen0", dm_ready, seen_done);
    end
    dm_load = 1'b1; dm_addr = 32'h0000_8000;
    tick();
    dm_load = 1'b0;
    wb_ack = 1'b1; wb_dat_i = 32'h600D_D00D;
    tick();
    wb_ack = 1'b0;
    n_cmp++;
    if ({ld_done, bus_err, dm_data_l, dm_ready} !== {2'b10, 32'h600D_D00D, 1'b1}) begin
      n_bad++; $display("FAIL midrst_next_load got ld%b be%b dl%h rdy%b exp ld1 be0 dl600DD00D rdy1",
        ld_done, bus_err, dm_data_l, dm_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load_fast_ack();
    test_store_wait();
    test_timeout();
    test_back_to_back();
    test_err_ack();
    test_reset_mid_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
